// File: rtl/rv_fetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response, redirect and decode handoff.
// master = fetch queue, slave = pipeline/memory environment.
interface rv_fetch_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] pc;
   logic            fetchReq;
   logic [31:0]     fetchI;
   logic            redirect;
   logic [XLEN-1:0] redirectPC;
   logic            pauseD;
   logic [31:0]     decodeI;
   logic [XLEN-1:0] decodePC;
   logic            validOut;
   logic [CW-1:0]   count;

   modport master (
      output pc, fetchReq, decodeI, decodePC, validOut, count,
      input  fetchI, redirect, redirectPC, pauseD
   );

   modport slave (
      input  pc, fetchReq, decodeI, decodePC, validOut, count,
      output fetchI, redirect, redirectPC, pauseD
   );
endinterface

// File: rtl/rv_fetch_queue.sv
// Instruction-fetch front end: PC generator plus DEPTH-entry prefetch queue feeding decode.
// Instruction memory has a fixed 1-cycle read latency; redirects flush the queue.
module rv_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   rv_fetch_queue_if.master  bus
);
   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [31:0]     NOP     = 32'h0000_0013;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic            inflight_q, inflight_d;
   logic            squash_q, squash_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

   logic [31:0]     instr_q [DEPTH];
   logic [XLEN-1:0] ipc_q   [DEPTH];

   logic            valid;
   logic            pop;
   logic            push;
   logic            fetch_req;
   logic [CW:0]     occ;
   logic [XLEN-1:0] redir_pc;

   assign redir_pc = bus.redirectPC & ~XLEN'(3);
   assign valid    = (count_q != '0);
   assign pop      = valid & ~bus.pauseD;
   assign push     = inflight_q & ~squash_q & ~bus.redirect;

   // Counting the pop lets a full queue refill in the same cycle it drains.
   assign occ       = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign fetch_req = reset & ~bus.redirect & (occ < DEPTH_C);

   always_comb begin
      pc_d          = pc_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      inflight_d    = fetch_req;
      inflight_pc_d = fetch_req ? pc_q : inflight_pc_q;
      squash_d      = 1'b0;
      if (bus.redirect) begin
         pc_d     = redir_pc;
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         squash_d = inflight_q;
      end else begin
         if (fetch_req) pc_d = pc_q + XLEN'(4);
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         inflight_q    <= 1'b0;
         squash_q      <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         inflight_q    <= inflight_d;
         squash_q      <= squash_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= NOP;
            ipc_q[i]   <= '0;
         end
      end else if (push) begin
         instr_q[wr_ptr_q] <= bus.fetchI;
         ipc_q[wr_ptr_q]   <= inflight_pc_q;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.fetchReq = fetch_req;
   assign bus.validOut = valid;
   assign bus.count    = count_q;
   assign bus.decodeI  = valid ? instr_q[rd_ptr_q] : NOP;
   assign bus.decodePC = valid ? ipc_q[rd_ptr_q] : '0;
endmodule
